zigzag_scan_8x8: RTL

//  Consumer end of the 8x8 row/column vector interface. Accepts one 8x8 block as 8 row words (8 x BW each) on
//  i_enable/i_data and emits its 64 coefficients one per transfer in JPEG zigzag order via valid/ready.

---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/zigzag_index_rom.sv | 16 +
 rtl/zigzag_scan_8x8.sv | 94 +++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and the zigzag scan table, used by both the
// forward zigzag scanner and the inverse zigzag.
package jpeg_pkg;

    localparam int BLK_N  = 8;
    localparam int BLK_SZ = 64;

    // Zigzag position k -> raster position r*8+c.
    localparam logic [5:0] ZZ_POS [BLK_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_rc(input logic [5:0] idx);
        return ZZ_POS[idx];
    endfunction

endpackage

// File: rtl/zigzag_index_rom.sv
// Combinational zigzag index to (row, column) lookup.
module zigzag_index_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] idx,
    output logic [2:0] row,
    output logic [2:0] col
);

    logic [5:0] pos;

    assign pos = zz_rc(idx);
    assign row = pos[5:3];
    assign col = pos[2:0];

endmodule

// File: rtl/zigzag_scan_8x8.sv
// Ping-pong buffered 8x8 block scanner: rows in, coefficients out in JPEG zigzag order.
module zigzag_scan_8x8
    import jpeg_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_enable,
    output logic            o_in_ready,
    output logic [BW-1:0]   o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_sop,
    output logic            o_eop,
    output logic            o_overflow
);

    // Output handshake: a coefficient moves on every edge where o_valid & i_ready;
    // while o_valid is high and i_ready is low, o_data/o_sop/o_eop stay put.
    logic [8*BW-1:0] bank_mem [2][BLK_N];
    logic [1:0]      full;
    logic            wr_bank;
    logic            rd_bank;
    logic [2:0]      wr_row;
    logic [5:0]      rd_idx;
    logic            overflow;

    logic            wr_en;
    logic            xfer;
    logic [2:0]      zz_row;
    logic [2:0]      zz_col;
    logic [2:0]      col_rev;
    logic [8*BW-1:0] sel_row;

    assign wr_en = i_enable & ~full[wr_bank];
    assign xfer  = full[rd_bank] & i_ready;

    // Storage needs no reset; the full flags decide what is meaningful.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            bank_mem[wr_bank][wr_row] <= i_data;
        end
    end

    // Write and read sides always target different banks when both touch full[].
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_row   <= 3'd0;
            rd_idx   <= 6'd0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (i_enable && full[wr_bank]) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                rd_idx <= rd_idx + 6'd1;
                if (rd_idx == 6'd63) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    zigzag_index_rom u_rom (
        .idx (rd_idx),
        .row (zz_row),
        .col (zz_col)
    );

    // Column 0 sits in the top slice of the row word.
    assign col_rev = ~zz_col;
    assign sel_row = bank_mem[rd_bank][zz_row];

    assign o_valid    = full[rd_bank];
    assign o_data     = o_valid ? sel_row[col_rev*BW +: BW] : '0;
    assign o_sop      = o_valid & (rd_idx == 6'd0);
    assign o_eop      = o_valid & (rd_idx == 6'd63);
    assign o_in_ready = ~full[wr_bank];
    assign o_overflow = overflow;

endmodule
